// File: rtl/alu_pkg.sv
// Shared ALU datapath package: comparator result encoding and comparator FSM states.
//   CMP_GT/CMP_LT/CMP_EQ/CMP_NONE : one-hot {gt, lt, eq} result codes
//   cmp_state_e                   : IDLE/RUN/DONE encoding of the sequential comparator
package alu_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_LT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_RUN  = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_e;

    // Map a chunk compare to a one-hot result code; equal chunks give CMP_EQ.
    function automatic logic [2:0] cmp_encode(input logic gt, input logic lt);
        logic [2:0] code;
        code = CMP_EQ;
        if (gt) begin
            code = CMP_GT;
        end else if (lt) begin
            code = CMP_LT;
        end
        return code;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare.
//   a, b : chunk operands
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
module cmp_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB chunk first,
// unsigned or two's-complement, with start/busy/done handshake and registered flags.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : request, accepted in IDLE or DONE
//   signed_mode         : 1 = two's-complement compare; sampled with start
//   a, b                : operands; sampled with start
//   busy                : comparison in progress (RUN)
//   done                : one-cycle pulse when flags are updated
//   a_gt_b/a_lt_b/a_eq_b: registered one-hot result, held until next done
// Build option: define SEQ_CMP_EARLY_EXIT_EN to finish on the first unequal chunk;
// undefined, every compare takes NCHUNK cycles (data-independent latency).
module seq_magnitude_comparator
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    cmp_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic [2:0]       res_q, res_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       flags_q, flags_d;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             c_gt, c_lt, c_eq;
    logic [2:0]       chunk_res;
    logic [2:0]       res_now;

    // Select chunk idx_q; idx 0 is the most-significant chunk.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDX_W'(k)) begin
                chunk_a = a_q[WIDTH-1-k*CHUNK -: CHUNK];
                chunk_b = b_q[WIDTH-1-k*CHUNK -: CHUNK];
            end
        end
    end

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_cmp_chunk (
        .a  (chunk_a),
        .b  (chunk_b),
        .gt (c_gt),
        .lt (c_lt),
        .eq (c_eq)
    );

    // An earlier decision wins; an undecided walk ending on an equal chunk is EQ.
    assign chunk_res = cmp_encode(c_gt, c_lt);
    assign res_now   = decided_q ? res_q : chunk_res;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        res_d     = res_q;
        a_d       = a_q;
        b_d       = b_q;
        flags_d   = flags_q;

        case (state_q)
            CMP_IDLE, CMP_DONE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto offset binary,
                    // so the chunk walk stays a plain unsigned compare.
                    a_d            = a;
                    a_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
                    b_d            = b;
                    b_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
                    idx_d          = '0;
                    decided_d      = 1'b0;
                    res_d          = CMP_NONE;
                    state_d        = CMP_RUN;
                end else begin
                    state_d = CMP_IDLE;
                end
            end

            CMP_RUN: begin
                if (!decided_q && !c_eq) begin
                    decided_d = 1'b1;
                    res_d     = chunk_res;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = CMP_DONE;
                    flags_d = res_now;
                end
`ifdef SEQ_CMP_EARLY_EXIT_EN
                else if (!decided_q && !c_eq) begin
                    state_d = CMP_DONE;
                    flags_d = res_now;
                end
`endif
            end

            default: begin
                state_d = CMP_IDLE;
            end
        endcase

        busy_d = (state_d == CMP_RUN);
        done_d = (state_d == CMP_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CMP_IDLE;
            idx_q     <= '0;
            decided_q <= 1'b0;
            res_q     <= CMP_NONE;
            a_q       <= '0;
            b_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flags_q   <= CMP_NONE;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            res_q     <= res_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            flags_q   <= flags_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_gt_b = flags_q[2];
    assign a_lt_b = flags_q[1];
    assign a_eq_b = flags_q[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4): directed cases,
// handshake/reset scenarios and randomized compares against an integer reference model.
module tb_seq_magnitude_comparator;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_flags;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .a_gt_b      (a_gt_b),
        .a_lt_b      (a_lt_b),
        .a_eq_b      (a_eq_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference result from plain integer comparison.
    function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s);
        int xv;
        int yv;
        if (s) begin
            xv = int'($signed(x));
            yv = int'($signed(y));
        end else begin
            xv = int'(x);
            yv = int'(y);
        end
        if (xv > yv) return 3'b100;
        if (xv < yv) return 3'b010;
        return 3'b001;
    endfunction

    // Expected start-to-done cycles.
    function automatic int ref_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int first_diff;
        int lat;
        first_diff = -1;
        for (int k = 0; k < int'(NCHUNK); k++) begin
            if (first_diff < 0 &&
                (((x >> (WIDTH - CHUNK * (k + 1))) & 16'hF) != ((y >> (WIDTH - CHUNK * (k + 1))) & 16'hF)))
                first_diff = k;
        end
        lat = int'(NCHUNK);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        if (first_diff >= 0) lat = first_diff + 1;
`endif
        return lat;
    endfunction

    // Issue one compare (called just after a clock edge) and wait for its done.
    task automatic cmp_txn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        int n;
        a           = x;
        b           = y;
        signed_mode = s;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        a           = WIDTH'($urandom);
        b           = WIDTH'($urandom);
        signed_mode = ~s;
        check("busy_after_start", 32'(busy), 32'd1);
        check("flags_kept_on_start", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(exp_flags));
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(ref_latency(x, y)));
        exp_flags = ref_flags(x, y, s);
        check("flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(exp_flags));
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("flags_hold", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(exp_flags));
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        int k;

        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        exp_flags   = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'd0);
        idle_cycle();

        // Directed cases
        cmp_txn(16'h1234, 16'h1234, 1'b0); idle_cycle();
        cmp_txn(16'h8000, 16'h7FFF, 1'b0); idle_cycle();
        cmp_txn(16'h8000, 16'h7FFF, 1'b1); idle_cycle();
        cmp_txn(16'hFFFF, 16'h0001, 1'b1); idle_cycle();
        cmp_txn(16'h1235, 16'h1234, 1'b0); idle_cycle();

        // Start while busy is ignored
        a = 16'h1235; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h0000; b = 16'hFFFF; start = 1'b1;
        check("busy_ignore_1", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("busy_ignore_2", 32'(busy), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        n = 2;
        while (!done && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("ignore_latency", 32'(n), 32'(NCHUNK));
        exp_flags = 3'b100;
        check("ignore_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(exp_flags));
        idle_cycle();

        // Back-to-back: each new start lands in the previous DONE cycle
        cmp_txn(16'h0001, 16'h0002, 1'b0);
        cmp_txn(16'hFFFE, 16'h0002, 1'b1);
        cmp_txn(16'hABCD, 16'hABCD, 1'b1);
        idle_cycle();

        // Reset during RUN aborts the compare
        a = 16'h1235; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'd0);
        rst_n = 1'b1;
        exp_flags = 3'b000;
        repeat (6) idle_cycle();

        // Randomized compares, some equal, some differing in a single chunk
        for (int i = 0; i < 200; i++) begin
            x = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: begin
                    y = x;
                    k = int'($urandom_range(0, NCHUNK - 1));
                    y[k*CHUNK +: CHUNK] = CHUNK'($urandom);
                end
                default: y = WIDTH'($urandom);
            endcase
            cmp_txn(x, y, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
